// File: rtl/data_sram_resp_pkg.sv
// data_sram_resp_pkg: shared FSM encodings, stall constants and request record
// Build option: DSRAM_RESP_WBUF_EN selects posted writes in data_sram_resp.
package data_sram_resp_pkg;

    localparam logic [3:0] S_IDLE = 4'b0001;
    localparam logic [3:0] S_REQ  = 4'b0010;
    localparam logic [3:0] S_WAIT = 4'b0100;
    localparam logic [3:0] S_DONE = 4'b1000;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wen;
    } req_t;

endpackage

// File: rtl/data_sram_resp_if.sv
// data_sram_resp_if: SRAM-like handshaked bus toward the cache/AXI bridge
// Ports (master = data_sram_resp side):
//   req/wr/wstrb/addr/wdata  request channel, held stable until addr_ok
//   addr_ok                  request accepted this cycle
//   data_ok/rdata            read data valid or write complete
interface data_sram_resp_if;

    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, wr, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, wstrb, addr, wdata, output addr_ok, data_ok, rdata);

endinterface

// File: rtl/data_sram_resp.sv
// data_sram_resp: turns the EX fixed-latency data-SRAM access into a bus transaction and stalls until done
// Ports:
//   clk, resetn (async, active low)
//   data_sram_en/wen/addr/wdata   access from EX (wen=0 means load)
//   data_sram_rdata               load data to MEM, held until the next load completes
//   stallreq_for_mem              combinational stall request
//   mem                           bus master port (data_sram_resp_if.master)
// Build option: DSRAM_RESP_WBUF_EN posts writes (leave on addr_ok, one write outstanding).
module data_sram_resp
    import data_sram_resp_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             data_sram_en,
    input  logic [3:0]       data_sram_wen,
    input  logic [31:0]      data_sram_addr,
    input  logic [31:0]      data_sram_wdata,
    output logic [31:0]      data_sram_rdata,
    output logic             stallreq_for_mem,
    data_sram_resp_if.master mem
);

`ifdef DSRAM_RESP_WBUF_EN
    localparam logic POSTED = 1'b1;
`else
    localparam logic POSTED = 1'b0;
`endif

    logic [3:0]  state_q, state_d;
    req_t        req_q, req_d;
    logic        wr_q, wr_d;
    logic        pend_q, pend_d;
    logic [31:0] rdata_q, rdata_d;
    logic        idle;

    assign idle             = state_q == S_IDLE;
    assign stallreq_for_mem = ((idle & data_sram_en) | state_q == S_REQ | state_q == S_WAIT) ? STOP : NO_STOP;
    assign mem.req          = state_q == S_REQ;
    assign mem.wr           = wr_q;
    assign mem.wstrb        = req_q.wen;
    assign mem.addr         = req_q.addr;
    assign mem.wdata        = req_q.wdata;
    assign data_sram_rdata  = rdata_q;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        // the outstanding posted write retires on whatever data_ok arrives while it is pending
        pend_d  = pend_q & ~mem.data_ok;
        case (state_q)
            S_IDLE: if (data_sram_en & ~pend_q) begin
                state_d = S_REQ;
                req_d   = '{addr: data_sram_addr, wdata: data_sram_wdata, wen: data_sram_wen};
                wr_d    = |data_sram_wen;
            end
            S_REQ: if (mem.addr_ok) begin
                state_d = (mem.data_ok | (POSTED & wr_q)) ? S_DONE : S_WAIT;
                pend_d  = POSTED & wr_q & ~mem.data_ok;
                rdata_d = (mem.data_ok & ~wr_q) ? mem.rdata : rdata_q;
            end
            S_WAIT: if (mem.data_ok) begin
                state_d = S_DONE;
                rdata_d = wr_q ? rdata_q : mem.rdata;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            wr_q    <= 1'b0;
            pend_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            pend_q  <= pend_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
